// File: rtl/axi_wr_master.sv
// AXI4 write-channel master: issues AW/W from a command and a user data stream, generates WLAST
// from the burst length, tracks outstanding bursts and reports B responses.
module axi_wr_master #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 64,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [AW-1:0]                cmd_addr,
    input  logic [7:0]                   cmd_len,
    input  logic [2:0]                   cmd_size,
    input  logic [1:0]                   cmd_burst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic                         cmd_err,
    input  logic [DW-1:0]                wdata_in,
    input  logic [DW/8-1:0]              wstrb_in,
    input  logic                         wvalid_in,
    output logic                         wready_out,
    output logic [AW-1:0]                axi_awaddr,
    output logic [7:0]                   axi_awlen,
    output logic [2:0]                   axi_awsize,
    output logic [1:0]                   axi_awburst,
    output logic                         axi_awvalid,
    input  logic                         axi_awready,
    output logic [DW-1:0]                axi_wdata,
    output logic [DW/8-1:0]              axi_wstrb,
    output logic                         axi_wlast,
    output logic                         axi_wvalid,
    input  logic                         axi_wready,
    input  logic [1:0]                   axi_bresp,
    input  logic                         axi_bvalid,
    output logic                         axi_bready,
    output logic                         resp_valid,
    output logic [1:0]                   resp_code,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic [7:0]                   err_count
);

    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = $clog2(MAX_OUT);
    localparam logic [OW-1:0] MaxOut  = OW'(MAX_OUT);
    localparam logic [2:0]    MaxSize = 3'($clog2(DW / 8));

    logic          cmd_hs, cmd_illegal, cmd_push, wrap_len_ok;
    logic          user_hs, last_beat, b_hs;
    logic [7:0]    len_mem [MAX_OUT];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] fifo_cnt_q;
    logic [7:0]    beat_cnt_q;
    logic [7:0]    head_len;

    // Gated by resetn so cmd_ready reads 0 while reset is held.
    assign cmd_ready   = resetn && !axi_awvalid && (outstanding < MaxOut);
    assign cmd_hs      = cmd_valid && cmd_ready;
    assign wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) ||
                         (cmd_len == 8'd15);
    assign cmd_illegal = (cmd_burst == 2'd3) || (cmd_size > MaxSize) ||
                         ((cmd_burst == 2'd2) && !wrap_len_ok);
    assign cmd_push    = cmd_hs && !cmd_illegal;

    assign head_len    = len_mem[rd_ptr_q];
    assign wready_out  = (fifo_cnt_q != '0) && (!axi_wvalid || axi_wready);
    assign user_hs     = wvalid_in && wready_out;
    assign last_beat   = (beat_cnt_q == head_len);

    assign axi_bready  = (outstanding != '0);
    assign b_hs        = axi_bvalid && axi_bready;

    // Length storage is not reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (cmd_push) len_mem[wr_ptr_q] <= cmd_len;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_err     <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awsize  <= '0;
            axi_awburst <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_wlast   <= 1'b0;
            axi_wvalid  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_code   <= '0;
            outstanding <= '0;
            err_count   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            beat_cnt_q  <= '0;
        end else begin
            cmd_err <= cmd_hs && cmd_illegal;

            if (cmd_push) begin
                axi_awaddr  <= cmd_addr;
                axi_awlen   <= cmd_len;
                axi_awsize  <= cmd_size;
                axi_awburst <= cmd_burst;
                axi_awvalid <= 1'b1;
            end else if (axi_awvalid && axi_awready) begin
                axi_awaddr  <= '0;
                axi_awlen   <= '0;
                axi_awsize  <= '0;
                axi_awburst <= '0;
                axi_awvalid <= 1'b0;
            end

            if (user_hs) begin
                axi_wdata  <= wdata_in;
                axi_wstrb  <= wstrb_in;
                axi_wvalid <= 1'b1;
                axi_wlast  <= last_beat;
                beat_cnt_q <= last_beat ? 8'd0 : beat_cnt_q + 8'd1;
            end else if (axi_wready) begin
                axi_wvalid <= 1'b0;
                axi_wlast  <= 1'b0;
            end

            if (cmd_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (user_hs && last_beat) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (cmd_push && !(user_hs && last_beat)) begin
                fifo_cnt_q <= fifo_cnt_q + OW'(1);
            end else if (!cmd_push && user_hs && last_beat) begin
                fifo_cnt_q <= fifo_cnt_q - OW'(1);
            end

            if (cmd_push && !b_hs) begin
                outstanding <= outstanding + OW'(1);
            end else if (!cmd_push && b_hs) begin
                outstanding <= outstanding - OW'(1);
            end

            resp_valid <= b_hs;
            if (b_hs) resp_code <= axi_bresp;
            if (b_hs && axi_bresp[1] && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_master.sv
// Scoreboard bench for axi_wr_master: stimulus pushes expected AW/W/B items, a monitor pops them.
module tb_axi_wr_master;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 64;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned OW      = $clog2(MAX_OUT + 1);

    logic            clk;
    logic            resetn;
    logic [AW-1:0]   cmd_addr;
    logic [7:0]      cmd_len;
    logic [2:0]      cmd_size;
    logic [1:0]      cmd_burst;
    logic            cmd_valid, cmd_ready, cmd_err;
    logic [DW-1:0]   wdata_in;
    logic [DW/8-1:0] wstrb_in;
    logic            wvalid_in, wready_out;
    logic [AW-1:0]   axi_awaddr;
    logic [7:0]      axi_awlen;
    logic [2:0]      axi_awsize;
    logic [1:0]      axi_awburst;
    logic            axi_awvalid, axi_awready;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wlast, axi_wvalid, axi_wready;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid, axi_bready;
    logic            resp_valid;
    logic [1:0]      resp_code;
    logic [OW-1:0]   outstanding;
    logic [7:0]      err_count;

    axi_wr_master #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_err(cmd_err),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in), .wready_out(wready_out),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .resp_valid(resp_valid), .resp_code(resp_code),
        .outstanding(outstanding), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cmd_err_seen = 0;
    logic [44:0] aw_q [$];
    logic [72:0] w_q [$];
    logic [1:0]  resp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bad_event(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s actual=%s required=none", name, what);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit legal);
        bit done = 0;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_valid = 1'b1;
        if (legal) aw_q.push_back({addr, len, size, burst});
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) done = 1;
        end
        if (!done) bad_event("cmd_timeout", "no_cmd_ready");
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
        bit done = 0;
        wdata_in  = data;
        wstrb_in  = strb;
        wvalid_in = 1'b1;
        w_q.push_back({data, strb, last});
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (wready_out) done = 1;
        end
        if (!done) bad_event("beat_timeout", "no_wready_out");
        tick();
        wvalid_in = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] resp);
        bit done = 0;
        axi_bresp  = resp;
        axi_bvalid = 1'b1;
        resp_q.push_back(resp);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (axi_bready) done = 1;
        end
        if (!done) bad_event("b_timeout", "no_bready");
        tick();
        axi_bvalid = 1'b0;
    endtask

    initial begin
        logic [44:0] aw_cur, aw_prev;
        bit          aw_pend;
        resetn      = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        cmd_size    = '0;
        cmd_burst   = '0;
        cmd_valid   = 1'b0;
        wdata_in    = '0;
        wstrb_in    = '0;
        wvalid_in   = 1'b0;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        axi_bresp   = '0;
        axi_bvalid  = 1'b0;
        aw_pend     = 0;
        aw_prev     = '0;

        fork
            forever begin
                @(negedge clk);
                if (!resetn) begin
                    aw_pend = 0;
                end else begin
                    aw_cur = {axi_awaddr, axi_awlen, axi_awsize, axi_awburst};
                    if (axi_awvalid) begin
                        if (aw_pend) check("aw_stable", aw_cur, aw_prev);
                        aw_prev = aw_cur;
                        aw_pend = !axi_awready;
                        if (axi_awready) begin
                            if (aw_q.size() == 0) bad_event("aw_unexpected", "handshake");
                            else check("aw_payload", aw_cur, aw_q.pop_front());
                        end
                    end else begin
                        aw_pend = 0;
                    end
                    if (axi_wvalid && axi_wready) begin
                        if (w_q.size() == 0) bad_event("w_unexpected", "handshake");
                        else check("w_beat", {axi_wdata, axi_wstrb, axi_wlast}, w_q.pop_front());
                    end
                    if (resp_valid) begin
                        if (resp_q.size() == 0) bad_event("resp_unexpected", "resp_valid");
                        else check("resp_code", resp_code, resp_q.pop_front());
                    end
                    if (cmd_err) cmd_err_seen++;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_valids", {axi_awvalid, axi_wvalid, axi_bready, resp_valid, cmd_err,
                             wready_out}, 6'b0);
        check("rst_counts", {outstanding, err_count}, '0);
        resetn = 1'b1;
        tick();
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Single INCR burst of 4 beats
        send_cmd(32'h1000, 8'd3, 3'd3, 2'd1, 1);
        check("t1_awvalid", axi_awvalid, 1'b1);
        check("t1_outstanding", outstanding, 3'd1);
        send_beat(64'h1111_0000_0000_0001, 8'hFF, 1'b0);
        send_beat(64'h2222_0000_0000_0002, 8'hFF, 1'b0);
        send_beat(64'h3333_0000_0000_0003, 8'h0F, 1'b0);
        send_beat(64'h4444_0000_0000_0004, 8'hF0, 1'b1);
        tick();
        check("t1_wait_b", outstanding, 3'd1);
        send_b(2'd0);
        check("t1_resp_valid", resp_valid, 1'b1);
        check("t1_outstanding_done", outstanding, 3'd0);

        // Fill to MAX_OUT outstanding
        for (int i = 0; i < 4; i++) send_cmd(32'h100 * i, 8'd0, 3'd2, 2'd1, 1);
        tick();
        check("t2_outstanding_full", outstanding, 3'd4);
        check("t2_cmd_ready_full", cmd_ready, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(64'hA0 + 64'(i), 8'h0F, 1'b1);
        send_b(2'd0);
        check("t2_outstanding_after_b", outstanding, 3'd3);
        check("t2_cmd_ready_back", cmd_ready, 1'b1);
        send_b(2'd1);
        send_b(2'd0);
        send_b(2'd1);
        check("t2_outstanding_drain", outstanding, 3'd0);
        check("t2_okay_no_err", err_count, 8'd0);

        // AW stalled while W proceeds
        axi_awready = 1'b0;
        send_cmd(32'h2000, 8'd1, 3'd3, 2'd1, 1);
        send_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
        send_beat(64'hDEAD_BEEF_0000_0002, 8'hFF, 1'b1);
        repeat (6) tick();
        check("t3_aw_held", axi_awvalid, 1'b1);
        check("t3_w_done", w_q.size(), 0);
        axi_awready = 1'b1;
        tick();
        check("t3_aw_cleared", axi_awvalid, 1'b0);
        check("t3_aw_consumed", aw_q.size(), 0);
        send_b(2'd0);

        // Illegal commands
        send_cmd(32'h5000, 8'd0, 3'd2, 2'd3, 0);
        send_cmd(32'h5000, 8'd2, 3'd3, 2'd2, 0);
        send_cmd(32'h5000, 8'd0, 3'd4, 2'd1, 0);
        tick();
        check("t4_cmd_err_count", cmd_err_seen, 3);
        check("t4_no_aw", axi_awvalid, 1'b0);
        check("t4_outstanding", outstanding, 3'd0);
        send_cmd(32'h6000, 8'd3, 3'd3, 2'd2, 1);
        check("t4_wrap_ok", outstanding, 3'd1);
        for (int i = 0; i < 4; i++) send_beat(64'hC0 + 64'(i), 8'hFF, (i == 3));
        send_b(2'd0);

        // Error count saturation
        for (int i = 0; i < 300; i++) begin
            send_cmd(32'h8000, 8'd0, 3'd3, 2'd1, 1);
            send_beat(64'(i), 8'hFF, 1'b1);
            send_b((i % 2 == 1) ? 2'd2 : 2'd3);
            if (i == 9) check("t5_err_10", err_count, 8'd10);
            if (i == 253) check("t5_err_254", err_count, 8'd254);
            if (i == 254) check("t5_err_255", err_count, 8'd255);
        end
        check("t5_err_sat", err_count, 8'd255);
        send_cmd(32'h9000, 8'd0, 3'd3, 2'd1, 1);
        send_beat(64'h77, 8'hFF, 1'b1);
        send_b(2'd1);
        check("t5_exokay_no_inc", err_count, 8'd255);

        // Reset in mid-burst
        send_cmd(32'hA000, 8'd7, 3'd3, 2'd1, 1);
        send_beat(64'hB0, 8'hFF, 1'b0);
        send_beat(64'hB1, 8'hFF, 1'b0);
        resetn = 1'b0;
        #1;
        check("t6_rst_valids", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, resp_valid,
                                cmd_ready, wready_out}, 7'b0);
        check("t6_rst_data", axi_wdata, 64'h0);
        check("t6_rst_counts", {outstanding, err_count}, '0);
        aw_q.delete();
        w_q.delete();
        resp_q.delete();
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        send_cmd(32'hC000, 8'd0, 3'd3, 2'd1, 1);
        send_beat(64'hFEED_FACE_CAFE_0001, 8'hFF, 1'b1);
        send_b(2'd0);
        check("t6_outstanding", outstanding, 3'd0);

        repeat (3) tick();
        check("end_aw_q_empty", aw_q.size(), 0);
        check("end_w_q_empty", w_q.size(), 0);
        check("end_resp_q_empty", resp_q.size(), 0);
        check("end_cmd_err_total", cmd_err_seen, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_wr_master.md
# axi_wr_master

Parametrised AXI4 write-channel master: the next generation of our write-channel FSM. It accepts burst commands and a user data stream, drives the AW and W channels, and generates WLAST from the burst length. It also tracks up to MAX_OUT outstanding bursts and reports B-channel responses with a saturating error count. It sits between user logic and the AXI slave port and is checked against the write-channel ILA model in the verification wrapper.

## Interface

- AW, 32, address width
- DW, 64, data width; one of 32/64/128
- MAX_OUT, 4, maximum outstanding bursts; power of two, 2–16
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cmd_addr / cmd_len / cmd_size / cmd_burst  in  AW/8/3/2  burst command
- cmd_valid  in  1 / cmd_ready  out  1  command handshake
- cmd_err  out  1  one-cycle pulse: illegal command dropped
- wdata_in / wstrb_in  in  DW / DW/8  user write beat
- wvalid_in  in  1 / wready_out  out  1  user data handshake
- axi_awaddr / axi_awlen / axi_awsize / axi_awburst  out  AW/8/3/2  AW payload
- axi_awvalid  out  1 / axi_awready  in  1
- axi_wdata / axi_wstrb  out  DW / DW/8 ; axi_wlast / axi_wvalid  out  1 ; axi_wready  in  1
- axi_bresp  in  2 ; axi_bvalid  in  1 ; axi_bready  out  1
- resp_valid  out  1 / resp_code  out  2  per-burst response report
- outstanding  out  clog2(MAX_OUT+1)  bursts accepted and not yet responded
- err_count  out  8  saturating count of SLVERR/DECERR

## Operation

- Command accept: cmd_ready = !axi_awvalid && outstanding < MAX_OUT. Handshake = cmd_valid && cmd_ready.
- Illegal command: cmd_burst==3; cmd_size > log2(DW/8); or WRAP with cmd_len not in {1,3,7,15}. It is consumed, not issued, and not counted. cmd_err pulses on the next cycle.
- Legal command: AW registers load and axi_awvalid is set. The length is pushed into a MAX_OUT-deep length FIFO, and outstanding increments.
- AW: axi_awvalid and payload are held stable until axi_awready; they clear on the handshake.
- W: a burst is active when the length FIFO is non-empty. A single output register holds the beat. wready_out = active && (!axi_wvalid || axi_wready).
  - On a user handshake, the register loads wdata/wstrb, sets axi_wvalid, and sets axi_wlast = (beat_cnt == head_len). beat_cnt increments.
  - On the last beat, beat_cnt resets to 0 and the FIFO is popped.
- W may lead AW only for bursts already accepted; W never runs ahead of commands.
- B: axi_bready = (outstanding != 0). On B handshake, outstanding decrements, resp_valid pulses next cycle with resp_code = axi_bresp, and err_count increments if bresp[1]==1, saturating at 255.
- Simultaneous accept + B handshake: outstanding is unchanged.
- A B handshake with outstanding==0 is impossible because bready is low.

## Timing

- Reset (resetn low, async): all outputs are 0, including cmd_ready during reset. Counters, FIFO, and beat_cnt clear. In-flight bursts are abandoned with no response.
- cmd handshake in cycle N → axi_awvalid high in N+1, outstanding updated in N+1.
- User beat handshake in N → axi_wvalid/wdata valid in N+1. Zero-bubble streaming while axi_wready stays high.
- B handshake in N → resp_valid in N+1, err_count in N+1.
- cmd_ready stays low while axi_awvalid is pending, so command throughput is 1 per 2 cycles minimum.
- FIFO full coincides with outstanding==MAX_OUT, so no overflow is possible.

## Test plan

- INCR, addr 0x1000, len 3, size 3 (DW=64), awready tied high, wready high, 4 beats → AW in cycle 1; W beats in cycles 2–5 with wlast only on beat 4; bresp OKAY → resp_valid, resp_code 0, outstanding 1→0.
- Issue 4 commands with bvalid held low → outstanding=4, cmd_ready=0. One OKAY B → outstanding=3, cmd_ready returns the next cycle.
- awready low for 10 cycles with a len=1 burst → AW payload stable throughout; both W beats still transfer; AW completes when awready rises.
- cmd_burst=3, then WRAP with len=2 → cmd_err pulses twice, no awvalid, outstanding stays 0.
- 300 SLVERR/DECERR responses → err_count saturates at 255; OKAY/EXOKAY do not increment it.
- resetn low in mid-burst (beat 2 of 8) → all outputs 0 immediately; after release, a fresh len=0 burst completes with wlast on its single beat.
